// File: rtl/spi_pkg.sv
// Shared definitions for the SPI byte receiver: FSM state encoding and
// the byte/bit-counter widths.
package spi_pkg;

    localparam int BYTE_W    = 8;
    localparam int BIT_CNT_W = 3;

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } state_t;

endpackage

// File: rtl/spi_byte_rx_if.sv
// Signal bundle between an SPI front end (master side: SCLK enable,
// chip-select, MOSI) and the byte receiver (slave side: frame and byte
// outputs).
//
// Handshake: there is no back-pressure. byte_valid, frame_start and
// frame_end are single-cycle pulses; byte_data/byte_cnt are qualified by
// byte_valid and held until the next byte completes.
interface spi_byte_rx_if #(
    parameter int CNT_WIDTH = 16
);
    import spi_pkg::*;

    logic                 sclk_rising;
    logic                 cs_n;
    logic                 mosi;
    logic                 frame_start;
    logic                 frame_end;
    logic                 byte_valid;
    logic [BYTE_W-1:0]    byte_data;
    logic [CNT_WIDTH-1:0] byte_cnt;

    modport master (
        output sclk_rising, cs_n, mosi,
        input  frame_start, frame_end, byte_valid, byte_data, byte_cnt
    );

    modport slave (
        input  sclk_rising, cs_n, mosi,
        output frame_start, frame_end, byte_valid, byte_data, byte_cnt
    );

endinterface

// File: rtl/spi_byte_rx.sv
// SPI mode-0 byte receiver. Assembles MOSI bits on each upstream SCLK
// rising-edge enable while chip-select is low and reports complete bytes
// with a per-frame index that saturates at all-ones.
// Optional feature: define SPI_BYTE_RX_LSB_FIRST_EN to assemble bits
// LSB-first; timing is identical in both builds.
module spi_byte_rx
    import spi_pkg::*;
#(
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk_in,
    input  logic                 rst_n_in,
    input  logic                 spi_sclk_rising_in,
    input  logic                 spi_cs_n_in,
    input  logic                 spi_mosi_in,
    output logic                 frame_start_out,
    output logic                 frame_end_out,
    output logic                 byte_valid_out,
    output logic [BYTE_W-1:0]    byte_data_out,
    output logic [CNT_WIDTH-1:0] byte_cnt_out,
    output state_t               state_out
);

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [BIT_CNT_W-1:0] BIT_LAST = '1;

    state_t               state_q;
    state_t               state_d;
    logic [BYTE_W-1:0]    shift_q;
    logic [BIT_CNT_W-1:0] bit_cnt_q;
    logic                 byte_seen_q;

    logic                 start_d;
    logic                 end_d;
    logic                 shift_en;
    logic                 byte_done;
    logic [BYTE_W-1:0]    assembled;

    assign state_out = state_q;

    // State register.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: chip-select level alone moves the FSM.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (!spi_cs_n_in) state_d = ACTIVE;
            ACTIVE:  if (spi_cs_n_in)  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output/control decode. CS deassert overrides a coincident 8th SCLK
    // enable because shifting is only allowed while CS is still low.
    always_comb begin
        start_d   = (state_q == IDLE)   && !spi_cs_n_in;
        end_d     = (state_q == ACTIVE) &&  spi_cs_n_in;
        shift_en  = (state_q == ACTIVE) && !spi_cs_n_in && spi_sclk_rising_in;
        byte_done = shift_en && (bit_cnt_q == BIT_LAST);
`ifdef SPI_BYTE_RX_LSB_FIRST_EN
        assembled = {spi_mosi_in, shift_q[BYTE_W-1:1]};
`else
        assembled = {shift_q[BYTE_W-2:0], spi_mosi_in};
`endif
    end

    // Datapath: shift register, bit counter, byte outputs and pulses.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            shift_q         <= '0;
            bit_cnt_q       <= '0;
            byte_seen_q     <= 1'b0;
            frame_start_out <= 1'b0;
            frame_end_out   <= 1'b0;
            byte_valid_out  <= 1'b0;
            byte_data_out   <= '0;
            byte_cnt_out    <= '0;
        end else begin
            frame_start_out <= start_d;
            frame_end_out   <= end_d;
            byte_valid_out  <= byte_done;

            if (start_d || end_d) begin
                // Entering or leaving a frame discards any partial byte.
                shift_q     <= '0;
                bit_cnt_q   <= '0;
                byte_seen_q <= 1'b0;
            end else if (shift_en) begin
                shift_q   <= assembled;
                bit_cnt_q <= bit_cnt_q + 1'b1;
            end

            if (byte_done) begin
                byte_data_out <= assembled;
                byte_seen_q   <= 1'b1;
                if (!byte_seen_q) begin
                    byte_cnt_out <= '0;
                end else if (byte_cnt_out != CNT_MAX) begin
                    byte_cnt_out <= byte_cnt_out + CNT_ONE;
                end
            end
        end
    end

endmodule
